// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one registered add/sub unit between the WB and LA requesters.
// Optional completion counters are enabled by defining ADDSUB_ARB_STATS_EN.
module addsub_arbiter #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            wb_valid_i,
    input  logic            wb_sub_i,
    input  logic [BITS-1:0] wb_wdata_i,
    output logic            wb_ready_o,
    output logic [BITS-1:0] wb_rdata_o,
    input  logic            la_valid_i,
    input  logic            la_sub_i,
    input  logic [BITS-1:0] la_wdata_i,
    output logic            la_ready_o,
    output logic [BITS-1:0] la_rdata_o,
    output logic            alu_nadd_sub_o,
    output logic [BITS-1:0] alu_wdata_o,
    input  logic [BITS-1:0] alu_rdata_i,
    output logic            busy_o,
    output logic            grant_la_o,
    output logic [15:0]     wb_ops_o,
    output logic [15:0]     la_ops_o
);

    localparam int unsigned CntW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            grant_la_q, grant_la_d;
    logic            alu_sub_q, alu_sub_d;
    logic [BITS-1:0] alu_wdata_q, alu_wdata_d;
    logic [BITS-1:0] wb_rdata_q, wb_rdata_d;
    logic [BITS-1:0] la_rdata_q, la_rdata_d;
    logic            pick_la;

    // On a tie the requester opposite to the last grant wins.
    assign pick_la = la_valid_i & (~wb_valid_i | ~grant_la_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            grant_la_q  <= 1'b1;
            alu_sub_q   <= 1'b0;
            alu_wdata_q <= '0;
            wb_rdata_q  <= '0;
            la_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_la_q  <= grant_la_d;
            alu_sub_q   <= alu_sub_d;
            alu_wdata_q <= alu_wdata_d;
            wb_rdata_q  <= wb_rdata_d;
            la_rdata_q  <= la_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_la_d  = grant_la_q;
        alu_sub_d   = alu_sub_q;
        alu_wdata_d = alu_wdata_q;
        wb_rdata_d  = wb_rdata_q;
        la_rdata_d  = la_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (wb_valid_i || la_valid_i) begin
                    grant_la_d  = pick_la;
                    alu_sub_d   = pick_la ? la_sub_i : wb_sub_i;
                    alu_wdata_d = pick_la ? la_wdata_i : wb_wdata_i;
                    cnt_d       = CntW'(ALU_LAT);
                    state_d     = StExec;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    if (grant_la_q) la_rdata_d = alu_rdata_i;
                    else            wb_rdata_d = alu_rdata_i;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o         = (state_q != StIdle);
        wb_ready_o     = (state_q == StResp) && !grant_la_q;
        la_ready_o     = (state_q == StResp) && grant_la_q;
        grant_la_o     = grant_la_q;
        alu_nadd_sub_o = alu_sub_q;
        alu_wdata_o    = alu_wdata_q;
        wb_rdata_o     = wb_rdata_q;
        la_rdata_o     = la_rdata_q;
    end

`ifdef ADDSUB_ARB_STATS_EN
    logic [15:0] wb_ops_q, wb_ops_d;
    logic [15:0] la_ops_q, la_ops_d;

    always_comb begin
        wb_ops_d = wb_ops_q;
        la_ops_d = la_ops_q;
        if (wb_ready_o && wb_ops_q != 16'hFFFF) wb_ops_d = wb_ops_q + 16'd1;
        if (la_ready_o && la_ops_q != 16'hFFFF) la_ops_d = la_ops_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wb_ops_q <= '0;
            la_ops_q <= '0;
        end else begin
            wb_ops_q <= wb_ops_d;
            la_ops_q <= la_ops_d;
        end
    end

    assign wb_ops_o = wb_ops_q;
    assign la_ops_o = la_ops_q;
`else
    assign wb_ops_o = 16'h0000;
    assign la_ops_o = 16'h0000;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter with a registered ALU model (latency 1).
module tb_addsub_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        wb_valid = 1'b0, wb_sub = 1'b0;
    logic [31:0] wb_wdata = '0;
    logic        la_valid = 1'b0, la_sub = 1'b0;
    logic [31:0] la_wdata = '0;
    logic        wb_ready, la_ready, alu_nadd_sub, busy, grant_la;
    logic [31:0] wb_rdata, la_rdata, alu_wdata;
    logic [31:0] alu_rdata = '0;
    logic [15:0] wb_ops, la_ops;

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.BITS(32), .ALU_LAT(1)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .wb_valid_i     (wb_valid),
        .wb_sub_i       (wb_sub),
        .wb_wdata_i     (wb_wdata),
        .wb_ready_o     (wb_ready),
        .wb_rdata_o     (wb_rdata),
        .la_valid_i     (la_valid),
        .la_sub_i       (la_sub),
        .la_wdata_i     (la_wdata),
        .la_ready_o     (la_ready),
        .la_rdata_o     (la_rdata),
        .alu_nadd_sub_o (alu_nadd_sub),
        .alu_wdata_o    (alu_wdata),
        .alu_rdata_i    (alu_rdata),
        .busy_o         (busy),
        .grant_la_o     (grant_la),
        .wb_ops_o       (wb_ops),
        .la_ops_o       (la_ops)
    );

    always #5 clk_i = ~clk_i;

    // Registered add/sub unit: 16-bit operands, zero-extended.
    always @(posedge clk_i) begin
        if (alu_nadd_sub) alu_rdata <= {16'h0, alu_wdata[31:16]} - {16'h0, alu_wdata[15:0]};
        else              alu_rdata <= {16'h0, alu_wdata[31:16]} + {16'h0, alu_wdata[15:0]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    // Called just after a posedge; n counts cycles from the current one (cycle 0).
    task automatic wait_ready(input bit la, output int lat, output bit other_seen);
        lat = -1;
        other_seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk_i);
            if (la ? wb_ready : la_ready) other_seen = 1'b1;
            if (la ? la_ready : wb_ready) begin
                lat = n;
                break;
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic single_op(input string tag, input bit la, input bit sub, input logic [31:0] wd,
                             input logic [31:0] exp);
        logic [31:0] other_before;
        int          lat;
        bit          seen;
        other_before = la ? wb_rdata : la_rdata;
        if (la) begin la_valid = 1'b1; la_sub = sub; la_wdata = wd; end
        else    begin wb_valid = 1'b1; wb_sub = sub; wb_wdata = wd; end
        @(posedge clk_i);
        #1;
        // Operands must already be latched; scrambling them now must not matter.
        if (la) la_wdata = 32'hDEAD_BEEF; else wb_wdata = 32'hDEAD_BEEF;
        wait_ready(la, lat, seen);
        check({tag, "_lat"}, 32'(lat + 1), 32'd3);
        check({tag, "_rdata"}, la ? la_rdata : wb_rdata, exp);
        check({tag, "_other_quiet"}, 32'(seen), 32'd0);
        check({tag, "_grant"}, 32'(grant_la), 32'(la));
        @(posedge clk_i);
        #1;
        if (la) la_valid = 1'b0; else wb_valid = 1'b0;
        check({tag, "_other_rdata"}, la ? wb_rdata : la_rdata, other_before);
    endtask

    initial begin
        int lat;
        bit seen;
        bit any_ready;

        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'({wb_ready, la_ready}), 32'd0);
        check("rst_grant_la", 32'(grant_la), 32'd1);
        check("rst_wb_rdata", wb_rdata, 32'd0);
        check("rst_alu_wdata", alu_wdata, 32'd0);

        // 1: WB only, 5+3
        single_op("t1", 1'b0, 1'b0, 32'h0005_0003, 32'h0000_0008);
        // 2: LA only, 3-5 wraps
        single_op("t2", 1'b1, 1'b1, 32'h0003_0005, 32'hFFFF_FFFE);

        // 3: simultaneous requests after reset, WB first then LA issuing in cycle 4
        do_reset();
        wb_valid = 1'b1; wb_sub = 1'b0; wb_wdata = 32'h0010_0020;
        la_valid = 1'b1; la_sub = 1'b1; la_wdata = 32'h0009_0002;
        wait_ready(1'b0, lat, seen);
        check("t3_wb_lat", 32'(lat), 32'd3);
        check("t3_la_quiet", 32'(seen), 32'd0);
        check("t3_grant_wb", 32'(grant_la), 32'd0);
        check("t3_wb_rdata", wb_rdata, 32'h0000_0030);
        @(posedge clk_i);
        #1 wb_valid = 1'b0;
        wait_ready(1'b1, lat, seen);
        check("t3_la_issue_c4", 32'(lat), 32'd3);
        check("t3_grant_la", 32'(grant_la), 32'd1);
        check("t3_la_rdata", la_rdata, 32'h0000_0007);
        @(posedge clk_i);
        #1 la_valid = 1'b0;

        // 4: WB held high, LA pending -> WB, LA, WB
        wb_valid = 1'b1; wb_sub = 1'b1; wb_wdata = 32'h0100_0001;
        la_valid = 1'b1; la_sub = 1'b0; la_wdata = 32'h0002_0003;
        wait_ready(1'b0, lat, seen);
        check("t4_wb1_lat", 32'(lat), 32'd3);
        check("t4_wb1_grant", 32'(grant_la), 32'd0);
        check("t4_wb1_rdata", wb_rdata, 32'h0000_00FF);
        @(posedge clk_i);
        #1 wb_wdata = 32'h0007_0004;
        wait_ready(1'b1, lat, seen);
        check("t4_la_lat", 32'(lat), 32'd3);
        check("t4_la_no_wb_twice", 32'(seen), 32'd0);
        check("t4_la_grant", 32'(grant_la), 32'd1);
        check("t4_la_rdata", la_rdata, 32'h0000_0005);
        @(posedge clk_i);
        #1 la_valid = 1'b0;
        wait_ready(1'b0, lat, seen);
        check("t4_wb2_lat", 32'(lat), 32'd3);
        check("t4_wb2_grant", 32'(grant_la), 32'd0);
        check("t4_wb2_rdata", wb_rdata, 32'h0000_0003);
        @(posedge clk_i);
        #1 wb_valid = 1'b0;

        // 5: reset during EXEC aborts asynchronously
        wb_valid = 1'b1; wb_sub = 1'b0; wb_wdata = 32'h0001_0001;
        @(posedge clk_i);
        #1 check("t5_busy_exec", 32'(busy), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        check("t5_busy_async", 32'(busy), 32'd0);
        check("t5_ready_async", 32'({wb_ready, la_ready}), 32'd0);
        check("t5_wb_rdata_clr", wb_rdata, 32'd0);
        check("t5_la_rdata_clr", la_rdata, 32'd0);
        wb_valid = 1'b0;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        any_ready = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (wb_ready || la_ready || busy) any_ready = 1'b1;
        end
        check("t5_no_pulse_after", 32'(any_ready), 32'd0);

        // 6: completion counters
        @(posedge clk_i);
        #1;
        do_reset();
        single_op("t6_wb1", 1'b0, 1'b0, 32'h0001_0002, 32'h0000_0003);
        single_op("t6_wb2", 1'b0, 1'b1, 32'h0009_0004, 32'h0000_0005);
        single_op("t6_la1", 1'b1, 1'b0, 32'h0004_0004, 32'h0000_0008);
        single_op("t6_wb3", 1'b0, 1'b0, 32'hFFFF_0001, 32'h0001_0000);
`ifdef ADDSUB_ARB_STATS_EN
        check("t6_wb_ops", 32'(wb_ops), 32'd3);
        check("t6_la_ops", 32'(la_ops), 32'd1);
        force dut.wb_ops_q = 16'hFFFF;
        #1 release dut.wb_ops_q;
        single_op("t6_wb_sat", 1'b0, 1'b0, 32'h0002_0002, 32'h0000_0004);
        check("t6_wb_ops_sat", 32'(wb_ops), 32'h0000_FFFF);
        check("t6_la_ops_hold", 32'(la_ops), 32'd1);
`else
        check("t6_wb_ops_off", 32'(wb_ops), 32'd0);
        check("t6_la_ops_off", 32'(la_ops), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
